// File: rtl/mesi_bus_ctrl_pkg.sv
// Shared MESI bus types: bus commands, cache line states
// and the bus controller FSM encoding.
package mesi_types;

  typedef enum logic [1:0] {
    No_OP   = 2'd0,
    BusRd   = 2'd1,
    BusRdX  = 2'd2,
    BusUpgr = 2'd3
  } bus_request;

  typedef enum logic [1:0] {
    Invalid,
    Shared,
    Exclusive,
    Modified
  } cache_state;

  typedef enum logic [2:0] {
    IDLE,
    SNOOP,
    WB,
    FETCH,
    RESP
  } bus_ctrl_state;

endpackage

// File: rtl/mesi_bus_ctrl_if.sv
// Snoopy bus bundle: core requests, snoop responses,
// broadcast/completion outputs and the memory port.
interface mesi_bus_ctrl_if
  import mesi_types::*;
#(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
);

  bus_request [NUM_CORES-1:0]             req_cmd;
  logic [NUM_CORES-1:0][ADDR_W-1:0]       req_addr;
  logic [NUM_CORES-1:0]                   snoop_hit;
  logic [NUM_CORES-1:0]                   snoop_dirty;
  logic [NUM_CORES-1:0][DATA_W-1:0]       wb_data;

  bus_request                             bus_cmd_out;
  logic [ADDR_W-1:0]                      bus_addr_out;
  logic [NUM_CORES-1:0]                   grant;
  logic [NUM_CORES-1:0]                   done;
  logic [DATA_W-1:0]                      fill_data;
  logic                                   exclusive;

  logic                                   mem_req;
  logic                                   mem_we;
  logic [ADDR_W-1:0]                      mem_addr;
  logic [DATA_W-1:0]                      mem_wdata;
  logic [DATA_W-1:0]                      mem_rdata;
  logic                                   mem_ack;

  modport master (
    input  req_cmd, req_addr, snoop_hit,
    input  snoop_dirty, wb_data,
    input  mem_rdata, mem_ack,
    output bus_cmd_out, bus_addr_out,
    output grant, done, fill_data, exclusive,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_cmd, req_addr, snoop_hit,
    output snoop_dirty, wb_data,
    output mem_rdata, mem_ack,
    input  bus_cmd_out, bus_addr_out,
    input  grant, done, fill_data, exclusive,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mesi_bus_ctrl_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last
// winner; pointer moves only when a grant is taken.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o,
  output logic         valid_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  // Walk farthest-first so the nearest requester is written last.
  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    for (int i = N; i >= 1; i--) begin
      logic [PW-1:0] idx;
      idx = PW'((int'(ptr_q) + i) % N);
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        ptr_d        = idx;
      end
    end
  end

  assign valid_o = |req_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PW'(N - 1);
    end else if (advance_i && valid_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mesi_bus_ctrl.sv
// MESI snoopy bus controller: arbitrate, broadcast one snoop
// cycle, write back / fetch from memory, then complete.
module mesi_bus_ctrl
  import mesi_types::*;
#(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
) (
  input logic            clk,
  input logic            rst,
  mesi_bus_ctrl_if.master bus
);

  logic [NUM_CORES-1:0] arb_req, arb_gnt;
  logic                 arb_valid, arb_adv;

  bus_request           win_cmd_d;
  logic [ADDR_W-1:0]    win_addr_d;
  logic [NUM_CORES-1:0] mhit_d, mdirty_d;
  logic [DATA_W-1:0]    wb_sel_d;

  bus_ctrl_state        state_q;
  bus_request           cmd_q, bus_cmd_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [NUM_CORES-1:0] grant_q, done_q;
  logic                 others_q, excl_q;
  logic                 mem_req_q, mem_we_q;
  logic [DATA_W-1:0]    wb_q, fill_q;

  assign arb_adv = (state_q == IDLE);

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (arb_req),
    .advance_i(arb_adv),
    .grant_o  (arb_gnt),
    .valid_o  (arb_valid)
  );

  always_comb begin
    win_cmd_d  = No_OP;
    win_addr_d = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      arb_req[c] = (bus.req_cmd[c] != No_OP);
      if (arb_gnt[c]) begin
        win_cmd_d  = bus.req_cmd[c];
        win_addr_d = bus.req_addr[c];
      end
    end
  end

  // Owner never snoops itself; lowest dirty index supplies data.
  always_comb begin
    mhit_d   = bus.snoop_hit & ~grant_q;
    mdirty_d = bus.snoop_dirty & ~grant_q;
    wb_sel_d = '0;
    for (int c = NUM_CORES - 1; c >= 0; c--) begin
      if (mdirty_d[c]) wb_sel_d = bus.wb_data[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= No_OP;
      bus_cmd_q <= No_OP;
      addr_q    <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      others_q  <= 1'b0;
      excl_q    <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      wb_q      <= '0;
      fill_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= '0;
          excl_q <= 1'b0;
          if (arb_valid) begin
            grant_q   <= arb_gnt;
            cmd_q     <= win_cmd_d;
            bus_cmd_q <= win_cmd_d;
            addr_q    <= win_addr_d;
            state_q   <= SNOOP;
          end
        end
        SNOOP: begin
          bus_cmd_q <= No_OP;
          others_q  <= |mhit_d;
          if (cmd_q == BusUpgr) begin
            done_q  <= grant_q;
            excl_q  <= 1'b0;
            state_q <= RESP;
          end else if (|mdirty_d) begin
            wb_q      <= wb_sel_d;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
            state_q   <= WB;
          end else begin
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
            state_q   <= FETCH;
          end
        end
        WB, FETCH: begin
          if (bus.mem_ack) begin
            fill_q    <= (state_q == WB) ? wb_q : bus.mem_rdata;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= grant_q;
            excl_q    <= (cmd_q == BusRd) && !others_q;
            state_q   <= RESP;
          end
        end
        RESP: begin
          done_q  <= '0;
          excl_q  <= 1'b0;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bus_cmd_out  = bus_cmd_q;
  assign bus.bus_addr_out = addr_q;
  assign bus.grant        = grant_q;
  assign bus.done         = done_q;
  assign bus.fill_data    = fill_q;
  assign bus.exclusive    = excl_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wb_q;

endmodule

// File: tb/tb_mesi_bus_ctrl.sv
// Directed bench for mesi_bus_ctrl: clean/dirty reads, upgrade,
// round-robin fairness, owner snoop masking and mid-flight reset.
module tb_mesi_bus_ctrl;
  import mesi_types::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mesi_bus_ctrl_if #(
    .NUM_CORES(2), .ADDR_W(8), .DATA_W(8)
  ) b ();

  mesi_bus_ctrl #(
    .NUM_CORES(2), .ADDR_W(8), .DATA_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(b.master)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic ack(input logic [7:0] d);
    b.mem_ack   = 1'b1;
    b.mem_rdata = d;
    tick();
    b.mem_ack   = 1'b0;
    b.mem_rdata = 8'h00;
  endtask

  task automatic xact(input int o, input logic [7:0] a,
                      input logic [7:0] d);
    tick();
    chk("rr_grant", 32'(b.grant), 32'(1 << o));
    chk("rr_cmd", 32'(b.bus_cmd_out), 32'(BusRdX));
    chk("rr_addr", 32'(b.bus_addr_out), 32'(a));
    tick();
    chk("rr_cmd_off", 32'(b.bus_cmd_out), 32'(No_OP));
    chk("rr_memreq", 32'(b.mem_req), 32'd1);
    ack(d);
    chk("rr_done", 32'(b.done), 32'(1 << o));
    chk("rr_excl", 32'(b.exclusive), 32'd0);
    chk("rr_fill", 32'(b.fill_data), 32'(d));
    b.req_cmd[o] = No_OP;
    tick();
    chk("rr_idle_cmd", 32'(b.bus_cmd_out), 32'(No_OP));
    chk("rr_idle_gnt", 32'(b.grant), 32'd0);
    b.req_cmd[o] = BusRdX;
  endtask

  initial begin
    rst           = 1'b1;
    b.req_cmd     = '{No_OP, No_OP};
    b.req_addr    = '0;
    b.snoop_hit   = '0;
    b.snoop_dirty = '0;
    b.wb_data     = '0;
    b.mem_rdata   = '0;
    b.mem_ack     = 1'b0;
    tick();
    tick();
    chk("rst_cmd", 32'(b.bus_cmd_out), 32'(No_OP));
    chk("rst_grant", 32'(b.grant), 32'd0);
    chk("rst_done", 32'(b.done), 32'd0);
    chk("rst_memreq", 32'(b.mem_req), 32'd0);
    chk("rst_excl", 32'(b.exclusive), 32'd0);
    chk("rst_fill", 32'(b.fill_data), 32'd0);
    rst = 1'b0;

    // clean BusRd, memory acks on second FETCH cycle
    b.req_cmd[0]  = BusRd;
    b.req_addr[0] = 8'h10;
    tick();
    chk("t1_cmd", 32'(b.bus_cmd_out), 32'(BusRd));
    chk("t1_addr", 32'(b.bus_addr_out), 32'h10);
    chk("t1_grant", 32'(b.grant), 32'd1);
    chk("t1_noreq", 32'(b.mem_req), 32'd0);
    tick();
    chk("t1_cmd_off", 32'(b.bus_cmd_out), 32'(No_OP));
    chk("t1_memreq", 32'(b.mem_req), 32'd1);
    chk("t1_we", 32'(b.mem_we), 32'd0);
    chk("t1_maddr", 32'(b.mem_addr), 32'h10);
    chk("t1_nodone", 32'(b.done), 32'd0);
    tick();
    chk("t1_hold", 32'(b.mem_req), 32'd1);
    ack(8'hA5);
    chk("t1_done", 32'(b.done), 32'd1);
    chk("t1_fill", 32'(b.fill_data), 32'hA5);
    chk("t1_excl", 32'(b.exclusive), 32'd1);
    chk("t1_memoff", 32'(b.mem_req), 32'd0);
    b.req_cmd[0] = No_OP;
    tick();
    chk("t1_done_off", 32'(b.done), 32'd0);
    chk("t1_gnt_off", 32'(b.grant), 32'd0);

    // stray ack while idle
    ack(8'hEE);
    chk("stray_memreq", 32'(b.mem_req), 32'd0);
    chk("stray_done", 32'(b.done), 32'd0);
    chk("stray_fill", 32'(b.fill_data), 32'hA5);

    // dirty BusRd: core1 holds line Modified
    b.req_cmd[0]     = BusRd;
    b.req_addr[0]    = 8'h20;
    b.snoop_hit[1]   = 1'b1;
    b.snoop_dirty[1] = 1'b1;
    b.wb_data[0]     = 8'h55;
    b.wb_data[1]     = 8'h3C;
    tick();
    chk("t2_cmd", 32'(b.bus_cmd_out), 32'(BusRd));
    tick();
    chk("t2_memreq", 32'(b.mem_req), 32'd1);
    chk("t2_we", 32'(b.mem_we), 32'd1);
    chk("t2_maddr", 32'(b.mem_addr), 32'h20);
    chk("t2_wdata", 32'(b.mem_wdata), 32'h3C);
    b.snoop_hit   = '0;
    b.snoop_dirty = '0;
    ack(8'h99);
    chk("t2_done", 32'(b.done), 32'd1);
    chk("t2_fill", 32'(b.fill_data), 32'h3C);
    chk("t2_excl", 32'(b.exclusive), 32'd0);
    chk("t2_memoff", 32'(b.mem_req), 32'd0);
    b.req_cmd[0] = No_OP;
    tick();

    // BusUpgr with a sharer: no memory traffic, done at t+2
    b.req_cmd[0]   = BusUpgr;
    b.req_addr[0]  = 8'h30;
    b.snoop_hit[1] = 1'b1;
    tick();
    chk("t3_cmd", 32'(b.bus_cmd_out), 32'(BusUpgr));
    chk("t3_addr", 32'(b.bus_addr_out), 32'h30);
    tick();
    chk("t3_done", 32'(b.done), 32'd1);
    chk("t3_excl", 32'(b.exclusive), 32'd0);
    chk("t3_memreq", 32'(b.mem_req), 32'd0);
    chk("t3_cmd_off", 32'(b.bus_cmd_out), 32'(No_OP));
    b.req_cmd[0]   = No_OP;
    b.snoop_hit[1] = 1'b0;
    tick();

    // owner's own snoop bits must be ignored
    b.req_cmd[0]     = BusRd;
    b.req_addr[0]    = 8'h50;
    b.snoop_hit[0]   = 1'b1;
    b.snoop_dirty[0] = 1'b1;
    b.wb_data[0]     = 8'h66;
    tick();
    tick();
    chk("t5_memreq", 32'(b.mem_req), 32'd1);
    chk("t5_we", 32'(b.mem_we), 32'd0);
    ack(8'h5A);
    chk("t5_done", 32'(b.done), 32'd1);
    chk("t5_fill", 32'(b.fill_data), 32'h5A);
    chk("t5_excl", 32'(b.exclusive), 32'd1);
    b.req_cmd[0]  = No_OP;
    b.snoop_hit   = '0;
    b.snoop_dirty = '0;
    tick();

    // reset during FETCH aborts the transaction
    b.req_cmd[0]  = BusRd;
    b.req_addr[0] = 8'h60;
    tick();
    tick();
    chk("t6_memreq", 32'(b.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_memreq", 32'(b.mem_req), 32'd0);
    chk("t6_rst_grant", 32'(b.grant), 32'd0);
    chk("t6_rst_done", 32'(b.done), 32'd0);
    tick();
    b.req_cmd[0] = No_OP;
    rst = 1'b0;
    chk("t6_after_done", 32'(b.done), 32'd0);
    b.req_cmd[1]  = BusRd;
    b.req_addr[1] = 8'h61;
    tick();
    chk("t6_grant1", 32'(b.grant), 32'd2);
    chk("t6_addr1", 32'(b.bus_addr_out), 32'h61);
    chk("t6_done0", 32'(b.done), 32'd0);
    tick();
    ack(8'h77);
    chk("t6_done1", 32'(b.done), 32'd2);
    chk("t6_fill1", 32'(b.fill_data), 32'h77);
    chk("t6_excl1", 32'(b.exclusive), 32'd1);
    b.req_cmd[1] = No_OP;
    tick();

    // contention: grants must alternate 0,1,0,1
    b.req_addr[0] = 8'h40;
    b.req_addr[1] = 8'h41;
    b.req_cmd[0]  = BusRdX;
    b.req_cmd[1]  = BusRdX;
    xact(0, 8'h40, 8'h11);
    xact(1, 8'h41, 8'h22);
    xact(0, 8'h40, 8'h33);
    xact(1, 8'h41, 8'h44);
    b.req_cmd = '{No_OP, No_OP};
    tick();
    chk("end_grant", 32'(b.grant), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mesi_bus_ctrl.md
Name: mesi_bus_ctrl

Overview:
Snoopy-bus controller and responder for the MESI cache array. It does four things:
- arbitrates bus requests (BusRd/BusRdX/BusUpgr) from NUM_CORES per-core cache controllers;
- broadcasts the winning command and address to every cache for one snoop cycle;
- collects snoop hit/dirty responses and performs the required writeback and line fetch against main memory;
- returns fill data plus the exclusive indication to the requester.

It sits between the per-core caches and the memory port.

Parameters:
NUM_CORES, 2, number of cache controllers on the bus (2..8)
ADDR_W, 8, address width
DATA_W, 8, line/data width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_cmd  in  NUM_CORES x bus_request  per-core request; No_OP = idle
req_addr  in  NUM_CORES x ADDR_W  per-core request address
snoop_hit  in  NUM_CORES  core holds a valid copy of bus_addr_out (S/E/M)
snoop_dirty  in  NUM_CORES  core holds bus_addr_out in Modified
wb_data  in  NUM_CORES x DATA_W  per-core line data for writeback
bus_cmd_out  out  bus_request  broadcast command, valid only in SNOOP
bus_addr_out  out  ADDR_W  broadcast address
grant  out  NUM_CORES  one-hot owner, held from SNOOP through RESP
done  out  NUM_CORES  one-cycle completion pulse to owner
fill_data  out  DATA_W  line data, valid with done (BusRd/BusRdX)
exclusive  out  1  no other sharer; valid with done for BusRd only
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one cycle

Behaviour:
- Reset (async, rst=1), all outputs 0:
  - bus_cmd_out=No_OP, grant=0, done=0, mem_req=0, exclusive=0;
  - state=IDLE, rr pointer=NUM_CORES-1, so core 0 wins first.
- Reset mid-transaction aborts it. No done is issued and mem_req drops immediately.
- FSM states: IDLE, SNOOP, WB, FETCH, RESP.
- IDLE:
  - If any req_cmd != No_OP, pick a winner round-robin, searching from pointer+1.
  - Register grant, bus_cmd_out=req_cmd[w], bus_addr_out=req_addr[w]; go to SNOOP.
  - Update pointer to w.
- SNOOP: exactly one cycle; bus_cmd_out broadcast. Snoop inputs are sampled at the end of the cycle, with the owner's bit masked.
  - others_hit = OR of masked snoop_hit. dirty = any masked snoop_dirty, with source d = lowest such index.
  - bus_cmd_out returns to No_OP after SNOOP; bus_addr_out holds until IDLE.
  - Next state: BusUpgr -> RESP. BusRd/BusRdX with dirty -> WB (wb_data[d] latched). Otherwise -> FETCH.
- WB: mem_req=1, mem_we=1, mem_addr=bus_addr_out, mem_wdata=latched data.
  - On mem_ack: fill register <= latched data; go to RESP. No re-read is needed because memory now equals the dirty data.
- FETCH: mem_req=1, mem_we=0, mem_addr=bus_addr_out.
  - On mem_ack: fill register <= mem_rdata; go to RESP.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are stable until mem_ack is sampled high; mem_req is low the cycle after.
  - mem_ack while mem_req=0 is ignored.
  - There is no timeout; the controller waits indefinitely.
- RESP: one cycle, then IDLE.
  - done[owner]=1, fill_data=fill register.
  - exclusive = (cmd==BusRd) & ~others_hit; it is 0 for BusRdX and BusUpgr.
  - grant drops on entry to IDLE.
- Latency, with req present in IDLE cycle t:
  - BusUpgr: done in cycle t+2.
  - Clean BusRd with mem_ack in the first FETCH cycle: done in t+3.
  - Dirty BusRd with single-cycle WB ack: done in t+3.
- Requester obligations:
  - Hold req_cmd/req_addr stable until done, and drop them in the cycle after done.
  - The controller never re-arbitrates in the done cycle.
  - A request withdrawn before grant is simply not selected.
- Requests arriving while not IDLE wait. Non-owner request changes are ignored after grant.
- Multiple snoop_dirty is a protocol violation; the lowest index wins and there is no other effect.

Decomposition:
- Package mesi_types: the existing bus_request (No_OP/BusRd/BusRdX/BusUpgr) and cache_state enums, plus a new bus_ctrl_state enum (IDLE/SNOOP/WB/FETCH/RESP).
- Sub-module rr_arbiter: parameter N; inputs clk, rst, req[N], advance; outputs grant one-hot and valid; owns the pointer.

Test Plan:
- Core0 BusRd 0x10, no sharers, mem_rdata=0xA5 acked after 2 cycles -> one SNOOP cycle with bus_cmd_out=BusRd/0x10; mem read 0x10; done[0], fill_data=0xA5, exclusive=1.
- Core1 holds 0x20 Modified (snoop_dirty[1]=1, wb_data[1]=0x3C); core0 BusRd 0x20 -> mem write 0x20=0x3C, no read; done[0], fill_data=0x3C, exclusive=0.
- Core0 BusUpgr 0x30 with core1 snoop_hit=1 -> bus_cmd_out=BusUpgr for 1 cycle, no mem_req, done[0] at t+2, exclusive=0.
- Both cores request BusRdX in the same cycle, twice in sequence -> grants core0, core1, core0, core1; bus_cmd_out never active in consecutive transactions without an intervening IDLE.
- Owner's own snoop_hit/snoop_dirty asserted on BusRd -> masked; exclusive=1, no WB.
- rst pulsed during FETCH with mem_req high -> mem_req=0, grant=0, done never pulses; next request from core1 alone is granted normally.
